jk_drive_sequencer: RTL and testbench

Upstream stimulus stage for the JK latch: accepts timed drive commands over a valid/ready handshake and buffers them in a small FIFO. It then replays each command as a `j`/`k` level held for a programmed number of clock cycles. Between commands it returns the latch inputs to hold (`j=k=0`). Its `j`/`k` outputs connect directly to the JK latch's `j`/`k` inputs, on the same `clk`.

---
 rtl/jk_pkg.sv | 14 +
 rtl/jk_cmd_fifo.sv | 45 ++++
 rtl/jk_drive_sequencer.sv | 103 ++++++++++
 tb/tb_jk_drive_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK latch drive sequencer: drive modes and FSM states.
package jk_pkg;

   localparam logic [1:0] MODE_HOLD   = 2'b00;
   localparam logic [1:0] MODE_RESET  = 2'b01;
   localparam logic [1:0] MODE_SET    = 2'b10;
   localparam logic [1:0] MODE_TOGGLE = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous show-ahead command FIFO; pointers carry one extra bit to tell full from empty.
module jk_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Reset only clears the pointers, which is enough to discard queued entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/jk_drive_sequencer.sv
// Replays buffered {mode,len} commands as registered j/k levels for the JK latch.
module jk_drive_sequencer
   import jk_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [CNT_W-1:0] cmd_len,
   output logic             j,
   output logic             k,
   output logic             busy,
   output logic             done
);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             j_n, k_n;
   logic             fifo_full, fifo_empty;
   logic             push, pop;
   logic [CNT_W+1:0] head;
   logic [CNT_W-1:0] head_len;

   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && cmd_ready;
   assign head_len  = (head[CNT_W-1:0] == '0) ? CNT_W'(1) : head[CNT_W-1:0];

   jk_cmd_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(CNT_W + 2)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .wdata({cmd_mode, cmd_len}),
      .rdata(head),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         j     <= 1'b0;
         k     <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         j     <= j_n;
         k     <= k_n;
      end
   end

   // The last drive cycle of a command pops the next one directly, so windows abut.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      j_n     = j;
      k_n     = k;
      pop     = 1'b0;
      case (state)
         ST_IDLE: begin
            j_n = 1'b0;
            k_n = 1'b0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               cnt_n   = head_len;
               j_n     = head[CNT_W+1];
               k_n     = head[CNT_W];
               state_n = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (cnt == CNT_W'(1)) begin
               if (!fifo_empty) begin
                  pop   = 1'b1;
                  cnt_n = head_len;
                  j_n   = head[CNT_W+1];
                  k_n   = head[CNT_W];
               end else begin
                  state_n = ST_IDLE;
                  cnt_n   = '0;
                  j_n     = 1'b0;
                  k_n     = 1'b0;
               end
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign done = (state == ST_DRIVE) && (cnt == CNT_W'(1));
   assign busy = (state == ST_DRIVE) || !fifo_empty;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Randomized self-checking bench for jk_drive_sequencer against a queue-based command model.
module tb_jk_drive_sequencer;
   import jk_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_mode = 2'b00;
   logic [CNT_W-1:0] cmd_len = '0;
   logic             j, k, busy, done;

   int checks = 0;
   int errors = 0;

   // Reference model: pending commands plus the remaining cycles of the active window.
   logic [CNT_W+1:0] modelQ[$];
   int               winLeft = 0;
   logic [1:0]       winMode = 2'b00;
   int               donePulses = 0;

   jk_drive_sequencer #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_mode (cmd_mode),
      .cmd_len  (cmd_len),
      .j        (j),
      .k        (k),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
      end
   endtask

   task automatic modelReset();
      modelQ.delete();
      winLeft = 0;
      winMode = 2'b00;
   endtask

   // A push is judged on the pre-edge occupancy; a pop only sees entries present before the edge.
   task automatic modelEdge(input logic v, input logic [1:0] m, input logic [CNT_W-1:0] l);
      logic             accept;
      logic [CNT_W+1:0] c;
      accept = v && (modelQ.size() < DEPTH);
      if (winLeft > 0) winLeft--;
      if (winLeft == 0 && modelQ.size() > 0) begin
         c       = modelQ.pop_front();
         winMode = c[CNT_W+1:CNT_W];
         winLeft = (c[CNT_W-1:0] == 0) ? 1 : int'(c[CNT_W-1:0]);
      end
      if (accept) modelQ.push_back({m, l});
   endtask

   task automatic compareAll(input string tag);
      logic expJ, expK, expDone, expBusy, expReady;
      expJ     = (winLeft > 0) ? winMode[1] : 1'b0;
      expK     = (winLeft > 0) ? winMode[0] : 1'b0;
      expDone  = (winLeft == 1);
      expBusy  = (winLeft > 0) || (modelQ.size() > 0);
      expReady = (modelQ.size() < DEPTH);
      checkOutput({tag, ".j"}, 32'(j), 32'(expJ));
      checkOutput({tag, ".k"}, 32'(k), 32'(expK));
      checkOutput({tag, ".done"}, 32'(done), 32'(expDone));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
      checkOutput({tag, ".ready"}, 32'(cmd_ready), 32'(expReady));
      if (expDone) donePulses++;
   endtask

   task automatic applyStimulus(input string tag, input logic v, input logic [1:0] m,
                                input logic [CNT_W-1:0] l);
      cmd_valid = v;
      cmd_mode  = m;
      cmd_len   = l;
      @(posedge clk);
      modelEdge(v, m, l);
      #1;
      compareAll(tag);
   endtask

   task automatic idleCycles(input string tag, input int n);
      for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, MODE_HOLD, '0);
   endtask

   initial begin
      int pulsesBefore;

      // Reset held for two edges, outputs checked while reset is active.
      modelReset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         compareAll("reset");
      end
      #2 rst = 1'b0;
      idleCycles("idle", 3);

      // Single set command of length 3.
      applyStimulus("set3", 1'b1, MODE_SET, 8'd3);
      idleCycles("set3", 6);

      // Latch bring-up sequence pushed back-to-back; expect five done pulses.
      pulsesBefore = donePulses;
      applyStimulus("seq", 1'b1, MODE_HOLD,   8'd2);
      applyStimulus("seq", 1'b1, MODE_SET,    8'd2);
      applyStimulus("seq", 1'b1, MODE_RESET,  8'd2);
      applyStimulus("seq", 1'b1, MODE_TOGGLE, 8'd2);
      applyStimulus("seq", 1'b1, MODE_HOLD,   8'd2);
      idleCycles("seq", 10);
      checkOutput("seq.donecount", 32'(donePulses - pulsesBefore), 32'd5);

      // Fill the FIFO behind a long command, then keep offering while full.
      applyStimulus("full", 1'b1, MODE_SET, 8'd6);
      for (int i = 0; i < 8; i++)
         applyStimulus("full", 1'b1, 2'(i), 8'd1);
      idleCycles("full", 12);

      // Length-0 command drives for exactly one cycle.
      applyStimulus("len0", 1'b1, MODE_TOGGLE, 8'd0);
      idleCycles("len0", 4);

      // Asynchronous reset during the second cycle of set/5 with two commands queued.
      applyStimulus("midrst", 1'b1, MODE_SET,    8'd5);
      applyStimulus("midrst", 1'b1, MODE_RESET,  8'd3);
      applyStimulus("midrst", 1'b1, MODE_TOGGLE, 8'd3);
      cmd_valid = 1'b0;
      #2 rst = 1'b1;
      modelReset();
      #1;
      compareAll("midrst.async");
      @(posedge clk);
      #1;
      compareAll("midrst.held");
      #2 rst = 1'b0;
      idleCycles("midrst.after", 8);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic v;
         v = ($urandom_range(0, 9) < 6);
         applyStimulus("rand", v, 2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 5)));
      end
      idleCycles("drain", 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
